// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer
// -------------------
// Holds a 4-bit value register that can be loaded from SW, stepped by hand
// (IDLE) or auto-counted by a prescaler (RUN), and shows it as two decimal
// digits on a pair of active-low 7-segment displays.
//
// Handshake/pulse semantics: load and step are single-cycle pulses sampled
// on the rising edge of CLOCK_50; run and up are levels. wrap and tick are
// registered single-cycle pulses that are high in the cycle right after the
// edge that caused them, i.e. the same cycle value shows the counted result.
//
// Parameters:
//   TICK_DIV   clock cycles per auto-count step in RUN (>= 2)
// Ports:
//   CLOCK_50   system clock, all state changes on its rising edge
//   Reset      synchronous active-high reset
//   SW[3:0]    load value
//   load       pulse: value <= SW, prescaler cleared, no count that cycle
//   run        level: 1 = auto-count, 0 = manual
//   step       pulse: one count while in IDLE (ignored in RUN)
//   up         count direction, 1 = increment, 0 = decrement
//   value[3:0] current value register
//   HEX0[6:0]  ones digit, active-low {g,f,e,d,c,b,a}, one cycle behind value
//   HEX1[6:0]  tens digit, active-low, one cycle behind value
//   wrap       pulse when a count wraps 15->0 (up) or 0->15 (down)
//   tick       pulse when the prescaler expires in RUN
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN)
// Build option:
//   BLANK_LEADING_ZERO_EN  when defined, HEX1 is dark (7'h7F) for value < 10,
//                          including its reset value.

module bcd_count_sequencer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [3:0] SW,
    input  logic       load,
    input  logic       run,
    input  logic       step,
    input  logic       up,
    output logic [3:0] value,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic       wrap,
    output logic       tick,
    output logic       state_dbg
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_ONE  = 7'b1111001;
`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [6:0] HEX1_LOW = 7'b1111111;
`else
    localparam logic [6:0] HEX1_LOW = SEG_ZERO;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [3:0]    value_n;
    logic          wrap_n, tick_n, do_count;

    assign state_dbg = (state == RUN);

    // State, prescaler, value and pulse registers.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
            pre   <= '0;
            value <= 4'd0;
            wrap  <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            value <= value_n;
            wrap  <= wrap_n;
            tick  <= tick_n;
        end
    end

    // Next-state and count logic. load outranks any count and holds the state.
    always_comb begin
        state_n  = state;
        pre_n    = pre;
        value_n  = value;
        wrap_n   = 1'b0;
        tick_n   = 1'b0;
        do_count = 1'b0;

        if (load) begin
            value_n = SW;
            pre_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    do_count = step;
                    if (run) begin
                        state_n = RUN;
                        pre_n   = '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_n = IDLE;
                        pre_n   = '0;
                    end else if (pre == PRE_LAST) begin
                        tick_n   = 1'b1;
                        do_count = 1'b1;
                        pre_n    = '0;
                    end else begin
                        pre_n = pre + PW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    pre_n   = '0;
                end
            endcase

            // 4-bit arithmetic wraps naturally; flag the wrap edge explicitly.
            if (do_count) begin
                if (up) begin
                    value_n = value + 4'd1;
                    wrap_n  = (value == 4'd15);
                end else begin
                    value_n = value - 4'd1;
                    wrap_n  = (value == 4'd0);
                end
            end
        end
    end

    // Decimal split: tens is set for 10..15, ones is then value - 10.
    logic       tens;
    logic [3:0] ones;
    logic [6:0] ones_seg;

    always_comb begin
        tens = value[3] & (value[2] | value[1]);
        ones = tens ? (value - 4'd10) : value;
        case (ones)
            4'd0:    ones_seg = 7'b1000000;
            4'd1:    ones_seg = 7'b1111001;
            4'd2:    ones_seg = 7'b0100100;
            4'd3:    ones_seg = 7'b0110000;
            4'd4:    ones_seg = 7'b0011001;
            4'd5:    ones_seg = 7'b0010010;
            4'd6:    ones_seg = 7'b0000010;
            4'd7:    ones_seg = 7'b1111000;
            4'd8:    ones_seg = 7'b0000000;
            4'd9:    ones_seg = 7'b0010000;
            default: ones_seg = 7'b1000000;
        endcase
    end

    // Displays are registered from the value register, so they trail it by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            HEX0 <= SEG_ZERO;
            HEX1 <= HEX1_LOW;
        end else begin
            HEX0 <= ones_seg;
            HEX1 <= tens ? SEG_ONE : HEX1_LOW;
        end
    end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Testbench for bcd_count_sequencer with TICK_DIV = 4.
// A cycle-level model tracks value as an integer with modulo-16 arithmetic,
// derives displayed digits with /10 and %10, and is compared against the
// DUT on every falling edge after reset. Directed literal checks pin the
// model to hand-computed values.

module tb_bcd_count_sequencer;

    localparam int TICK_DIV = 4;

`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [6:0] HEX1_LOW = 7'b1111111;
`else
    localparam logic [6:0] HEX1_LOW = 7'b1000000;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       load, run, step, up;
    logic [3:0] value;
    logic [6:0] hex0, hex1;
    logic       wrap, tick, state_dbg;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    bcd_count_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50  (clk),
        .Reset     (rst),
        .SW        (sw),
        .load      (load),
        .run       (run),
        .step      (step),
        .up        (up),
        .value     (value),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .wrap      (wrap),
        .tick      (tick),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'bxxxxxxx;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Advance n rising edges; inputs change and literal checks happen 1 time unit after.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        sw   = 4'(v);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_step(input bit dir);
        up   = dir;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    int m_val, m_shown, m_pre;
    bit m_running, m_wrap, m_tick;

    function automatic void m_count(input bit dir);
        if (dir) begin
            m_wrap = (m_val == 15);
            m_val  = (m_val + 1) % 16;
        end else begin
            m_wrap = (m_val == 0);
            m_val  = (m_val + 15) % 16;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_shown = 0; m_pre = 0;
            m_running = 0; m_wrap = 0; m_tick = 0;
        end else begin
            m_shown = m_val;
            m_wrap  = 0;
            m_tick  = 0;
            if (load) begin
                m_val = int'(sw);
                m_pre = 0;
            end else if (!m_running) begin
                if (step) m_count(up);
                if (run) begin
                    m_running = 1;
                    m_pre = 0;
                end
            end else if (!run) begin
                m_running = 0;
                m_pre = 0;
            end else begin
                m_pre = m_pre + 1;
                if (m_pre == TICK_DIV) begin
                    m_tick = 1;
                    m_count(up);
                    m_pre = 0;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("value", int'(value), m_val);
            check("HEX0",  int'(hex0), int'(seg(m_shown % 10)));
            check("HEX1",  int'(hex1), int'((m_shown >= 10) ? seg(1) : HEX1_LOW));
            check("wrap",  int'(wrap), int'(m_wrap));
            check("tick",  int'(tick), int'(m_tick));
            check("state", int'(state_dbg), int'(m_running));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; sw = 4'd0; load = 0; run = 0; step = 0; up = 1;
        cyc(2);
        check_en = 1;
        rst = 1'b0;

        // Reset then idle.
        cyc(3);
        check("lit_reset_value", int'(value), 0);
        check("lit_reset_hex0", int'(hex0), int'(7'b1000000));
        check("lit_reset_hex1", int'(hex1), int'(HEX1_LOW));
        check("lit_reset_wrap", int'(wrap), 0);
        check("lit_reset_tick", int'(tick), 0);

        // Load 13, display follows one cycle later.
        do_load(13);
        check("lit_load13_value", int'(value), 13);
        cyc(1);
        check("lit_load13_hex1", int'(hex1), int'(7'b1111001));
        check("lit_load13_hex0", int'(hex0), int'(7'b0110000));

        // SW changes without load are ignored.
        sw = 4'd5;
        cyc(2);
        check("lit_sw_noload", int'(value), 13);

        // Wrap up and down in IDLE.
        do_load(15);
        do_step(1'b1);
        check("lit_wrap_up_value", int'(value), 0);
        check("lit_wrap_up_pulse", int'(wrap), 1);
        cyc(1);
        check("lit_wrap_up_clear", int'(wrap), 0);
        do_step(1'b0);
        check("lit_wrap_dn_value", int'(value), 15);
        check("lit_wrap_dn_pulse", int'(wrap), 1);
        cyc(1);

        // Auto-count from 0: a tick every 4 cycles.
        up = 1'b1;
        do_load(0);
        run = 1'b1;
        cyc(4);
        check("lit_run_pre_tick", int'(value), 0);
        cyc(1);
        check("lit_run_v1", int'(value), 1);
        check("lit_run_tick1", int'(tick), 1);
        cyc(4);
        check("lit_run_v2", int'(value), 2);
        cyc(4);
        check("lit_run_v3", int'(value), 3);
        step = 1'b1;   // ignored in RUN
        cyc(1);
        step = 1'b0;
        check("lit_run_step_ignored", int'(value), 3);
        run = 1'b0;
        cyc(8);
        check("lit_frozen", int'(value), 3);
        check("lit_idle_state", int'(state_dbg), 0);

        // Load collides with a tick.
        run = 1'b1;
        cyc(4);               // enter RUN, prescaler now at its last count
        sw = 4'd9; load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("lit_load_tick_value", int'(value), 9);
        check("lit_load_tick_wrap", int'(wrap), 0);
        cyc(3);
        check("lit_load_tick_hold", int'(value), 9);
        cyc(1);
        check("lit_after_load_v10", int'(value), 10);

        // Auto-count through the 15 -> 0 wrap.
        do_load(14);
        cyc(8);
        check("lit_run_wrap_value", int'(value), 0);
        check("lit_run_wrap_pulse", int'(wrap), 1);

        // Reset in the middle of RUN.
        do_load(7);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("lit_rst_run_state", int'(state_dbg), 0);
        check("lit_rst_run_value", int'(value), 0);
        rst = 1'b0; run = 1'b0;
        cyc(6);
        check("lit_rst_tick", int'(tick), 0);

        // Display decode of every value.
        for (int v = 0; v < 16; v++) begin
            do_load(v);
            cyc(1);
        end
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
